// File: rtl/chunk_packer_if.sv
// rtl/chunk_packer_if.sv - nibble-in / word-out bundle for chunk_packer; out_parity only with CHUNK_PACKER_PARITY_EN
interface chunk_packer_if #(
   parameter int CHUNKS = 2,
   parameter int DEPTH  = 4
) ();
   localparam int W  = 4 * CHUNKS;
   localparam int LW = $clog2(DEPTH) + 1;

   logic          have_output;
   logic [3:0]    in_bits;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [LW-1:0] level;
   logic          overflow;
`ifdef CHUNK_PACKER_PARITY_EN
   logic          out_parity;
`endif

   modport master (
`ifdef CHUNK_PACKER_PARITY_EN
      input  out_parity,
`endif
      output have_output, in_bits, flush, out_ready,
      input  out_valid, out_data, level, overflow
   );

   modport slave (
`ifdef CHUNK_PACKER_PARITY_EN
      output out_parity,
`endif
      input  have_output, in_bits, flush, out_ready,
      output out_valid, out_data, level, overflow
   );
endinterface

// File: rtl/chunk_packer.sv
// rtl/chunk_packer.sv - packs out_chunks nibbles MSB-first into words behind a FIFO; CHUNK_PACKER_PARITY_EN adds out_parity
module chunk_packer #(
   parameter int CHUNKS = 2,
   parameter int DEPTH  = 4
) (
   input logic           clk,
   input logic           reset,
   chunk_packer_if.slave bus
);
   localparam int W  = 4 * CHUNKS;
   localparam int IW = $clog2(CHUNKS + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
`ifdef CHUNK_PACKER_PARITY_EN
   localparam int EW = W + 1;
`else
   localparam int EW = W;
`endif
   localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] ONE_LVL  = LW'(1);

   logic [IW-1:0] idx;
   logic [W-1:0]  asm_q;
   logic [W-1:0]  asm_next;
   logic          word_done;
   logic [EW-1:0] push_entry;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_next;
   logic [LW-1:0] count;
   logic [EW-1:0] head_q;
   logic          overflow_q;

   logic          empty;
   logic          full;
   logic          pop;
   logic          push;

   // Low nibbles of asm_q are always zero, so a flushed word is zero-filled for free.
   always_comb begin
      asm_next = asm_q;
      for (int k = 0; k < CHUNKS; k++) begin
         if (bus.have_output && idx == IW'(k))
            asm_next[W-1-4*k -: 4] = bus.in_bits;
      end
      word_done = (bus.have_output && idx == LAST_IDX) ||
                  (bus.flush && (bus.have_output || idx != '0));
   end

`ifdef CHUNK_PACKER_PARITY_EN
   assign push_entry = {^asm_next, asm_next};
`else
   assign push_entry = asm_next;
`endif

   assign empty   = (count == '0);
   assign full    = (count == FULL_LVL);
   assign pop     = !empty && bus.out_ready;
   assign push    = word_done && (!full || pop);
   assign rd_next = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         idx   <= '0;
         asm_q <= '0;
      end else if (word_done) begin
         idx   <= '0;
         asm_q <= '0;
      end else if (bus.have_output) begin
         idx   <= idx + 1'b1;
         asm_q <= asm_next;
      end
   end

   // On a full push+pop the write lands in the slot being vacated, which head_q already holds.
   always_ff @(posedge clk) begin
      if (!reset && push)
         mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_next;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (empty && push)
            head_q <= push_entry;
         else if (pop) begin
            if (count > ONE_LVL)
               head_q <= mem[rd_next];
            else if (push)
               head_q <= push_entry;
         end

         if (word_done && full && !pop)
            overflow_q <= 1'b1;
      end
   end

   assign bus.out_valid = !empty;
   assign bus.out_data  = head_q[W-1:0];
   assign bus.level     = count;
   assign bus.overflow  = overflow_q;
`ifdef CHUNK_PACKER_PARITY_EN
   assign bus.out_parity = head_q[W];
`endif

endmodule

// File: tb/tb_chunk_packer.sv
// tb/tb_chunk_packer.sv - scoreboard bench for chunk_packer with directed nibble vectors
module tb_chunk_packer;
   localparam int CHUNKS = 2;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   chunk_packer_if #(.CHUNKS(CHUNKS), .DEPTH(DEPTH)) bus ();

   chunk_packer #(.CHUNKS(CHUNKS), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nib(input logic [3:0] v, input logic fl);
      bus.have_output = 1'b1;
      bus.in_bits     = v;
      bus.flush       = fl;
      step();
      bus.have_output = 1'b0;
      bus.in_bits     = 4'h0;
      bus.flush       = 1'b0;
   endtask

   task automatic word(input logic [7:0] w);
      nib(w[7:4], 1'b0);
      nib(w[3:0], 1'b0);
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while ((bus.out_valid || exp_q.size() != 0) && n < max_cycles) begin
         step();
         n++;
      end
      chk("drain_in_time", 32'(n < max_cycles), 32'd1);
   endtask

   // Monitor: a handshake seen here completes on the next rising edge.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h expected=none at %0t", bus.out_data, $time);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e));
`ifdef CHUNK_PACKER_PARITY_EN
            chk("out_parity", 32'(bus.out_parity), 32'(^e));
`endif
         end
      end
   end

   initial begin
      reset           = 1'b1;
      bus.have_output = 1'b0;
      bus.in_bits     = 4'h0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b1;
      step();
      step();
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_level", 32'(bus.level), 32'd0);
      chk("reset_overflow", 32'(bus.overflow), 32'd0);
      chk("reset_out_data", 32'(bus.out_data), 32'd0);
      reset = 1'b0;
      step();

      // basic pack, one-cycle latency
      nib(4'hA, 1'b0);
      chk("basic_no_early_valid", 32'(bus.out_valid), 32'd0);
      exp_q.push_back(8'hA5);
      nib(4'h5, 1'b0);
      chk("basic_valid_latency", 32'(bus.out_valid), 32'd1);
      chk("basic_head", 32'(bus.out_data), 32'hA5);
      step();
      step();
      chk("basic_level_zero", 32'(bus.level), 32'd0);
      chk("basic_valid_low", 32'(bus.out_valid), 32'd0);

      // gapped input
      nib(4'h3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("gap_no_output", 32'(bus.out_valid), 32'd0);
      end
      exp_q.push_back(8'h3C);
      nib(4'hC, 1'b0);
      drain(10);

      // flush variants
      nib(4'h7, 1'b0);
      exp_q.push_back(8'h70);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      exp_q.push_back(8'h12);
      word(8'h12);
      exp_q.push_back(8'h34);
      nib(4'h3, 1'b0);
      nib(4'h4, 1'b1);
      exp_q.push_back(8'h90);
      nib(4'h9, 1'b1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      drain(20);
      step();
      chk("flush_level_zero", 32'(bus.level), 32'd0);

      // backpressure and overflow
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         logic [7:0] w;
         w = 8'(i * 8'h11);
         if (i <= DEPTH)
            exp_q.push_back(w);
         word(w);
      end
      chk("ovf_level_full", 32'(bus.level), 32'd4);
      chk("ovf_sticky", 32'(bus.overflow), 32'd1);
      chk("ovf_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_head_stable", 32'(bus.out_data), 32'h11);
      end
      bus.out_ready = 1'b1;
      drain(20);
      chk("ovf_drained_valid", 32'(bus.out_valid), 32'd0);
      chk("ovf_drained_level", 32'(bus.level), 32'd0);
      chk("ovf_survives_drain", 32'(bus.overflow), 32'd1);

      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_clears_overflow", 32'(bus.overflow), 32'd0);

      // full FIFO with push and pop on the same edge
      bus.out_ready = 1'b0;
      exp_q.push_back(8'hA1);
      word(8'hA1);
      exp_q.push_back(8'hB2);
      word(8'hB2);
      exp_q.push_back(8'hC3);
      word(8'hC3);
      exp_q.push_back(8'hD4);
      word(8'hD4);
      nib(4'hE, 1'b0);
      exp_q.push_back(8'hEF);
      bus.out_ready = 1'b1;
      nib(4'hF, 1'b0);
      bus.out_ready = 1'b0;
      chk("full_pop_level", 32'(bus.level), 32'd4);
      chk("full_pop_no_overflow", 32'(bus.overflow), 32'd0);
      chk("full_pop_new_head", 32'(bus.out_data), 32'hB2);
      bus.out_ready = 1'b1;
      drain(20);

      // reset mid-word discards the partial nibble
      nib(4'hF, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.push_back(8'h12);
      word(8'h12);
      drain(10);
      chk("midword_overflow", 32'(bus.overflow), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/chunk_packer.md
Name: chunk_packer

Overview:
- Downstream of out_chunks; consumes its nibble stream (have_output strobe + 4-bit out_bits) and reassembles it into full-width words.
- Completed words are buffered in a small FIFO and offered on a valid/ready interface to the host-side drain logic (pin mux / readback).
- Absorbs the gap between the sorter's bursty output and a stalling consumer; reports sticky overflow if the FIFO cannot accept a word.

Parameters:
- CHUNKS, 2, nibbles per word; word width W = 4*CHUNKS; legal range 1..8.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- have_output  in  1  nibble strobe from out_chunks; in_bits valid when high.
- in_bits  in  4  nibble from out_chunks.
- flush  in  1  pad the partial word with zero nibbles and push it.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer accepts head word.
- out_data  out  W  head word (out_data[W-1:0]).
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset (synchronous, takes priority over all inputs): nibble index = 0, assembly register = 0, FIFO empty, out_valid = 0, out_data = 0, level = 0, overflow = 0. Asserting reset mid-word discards the partial word and all buffered words.
- Assembly order: the first nibble after reset or a word boundary is the most significant (bits W-1:W-4); the last nibble is bits 3:0.
- Each cycle with have_output = 1 captures one nibble. Gaps (have_output = 0) are allowed at any point; the partial word is held indefinitely.
- Word completes on the cycle the CHUNKS-th nibble is captured. The push happens on that same edge; out_valid rises the next cycle if the FIFO was empty. Latency from last nibble to out_valid = 1 cycle.
- flush = 1 with nibble index > 0:
  - The current cycle's nibble, if any, is included first.
  - Remaining low nibbles are zero-filled and the word is pushed on that edge.
  - Index returns to 0.
- flush = 1 with index 0 and no nibble: no effect.
- flush together with the nibble that completes a word: push once, no extra word.
- Pop: an out_valid && out_ready handshake at an edge removes the head word. out_data shows the next entry, or holds its last value with out_valid = 0 if the FIFO is now empty.
- Full FIFO (level == DEPTH) when a word completes:
  - If a pop occurs on the same edge, the push is accepted and level stays DEPTH.
  - Otherwise the new word is dropped, overflow is set, and the FIFO contents are unchanged.
- Push and pop on the same edge when the FIFO is empty: not possible, since the head word is registered; the push lands and out_valid rises next cycle.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- overflow clears only on reset.
- out_data is stable while out_valid && !out_ready.

Optional Feature:
- Macro: CHUNK_PACKER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR of all bits of the head word, stored in the FIFO alongside the data.
  - Reset value 0; valid whenever out_valid = 1.
- Undefined: port absent, FIFO holds W bits only; all other behaviour identical.

Test Plan:
- Basic pack (CHUNKS=2): strobe nibbles 0xA then 0x5 on consecutive cycles, out_ready = 1 -> out_valid high one cycle after second nibble, out_data = 0xA5, level returns to 0.
- Gapped input: nibble 0x3, 5 idle cycles, nibble 0xC -> single word 0x3C, no output during the gap.
- Flush partial: nibble 0x7 then flush = 1 alone -> word 0x70 pushed; next nibbles 0x1, 0x2 -> word 0x12.
- Backpressure/overflow (DEPTH=4): out_ready = 0, push 5 words 0x11,0x22,0x33,0x44,0x55 -> level = 4, overflow = 1; drain yields 0x11,0x22,0x33,0x44 in order, then out_valid = 0.
- Full with simultaneous pop: FIFO full, complete a word on the same edge as a handshake -> no overflow, level stays 4, new word appears last in drain order.
- Reset mid-word: nibble 0xF, reset 1 cycle, nibbles 0x1, 0x2 -> only word 0x12 emitted, overflow = 0; with CHUNK_PACKER_PARITY_EN, out_parity = 0 for 0x12.
